// File: rtl/bikelight_pkg.sv
// Shared mode encodings and the mode-cycle helper for the bike light controllers.
package bikelight_pkg;

    localparam int unsigned MODE_W = 4;

    typedef logic [MODE_W-1:0] mode_t;

    localparam logic [3:0] MODE_OFF   = 4'b0001;
    localparam logic [3:0] MODE_ON    = 4'b0010;
    localparam logic [3:0] MODE_BLINK = 4'b0100;
    localparam logic [3:0] MODE_DIM   = 4'b1000;

    // Button-press mode cycle; any illegal encoding recovers to OFF.
    function automatic mode_t next_mode(input mode_t mode);
        mode_t nxt;
        case (mode)
            MODE_OFF:   nxt = MODE_ON;
            MODE_ON:    nxt = MODE_BLINK;
            MODE_BLINK: nxt = MODE_DIM;
            default:    nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bikelight_debounce.sv
// Per-button 2-flop synchroniser, counting debouncer and registered rising-edge pulse.
module bikelight_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);
    localparam int unsigned     CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_accept;

    assign w_diff   = r_sync2 ^ r_deb;
    assign w_accept = w_diff && (r_cnt == CNT_LAST);

    // Any sample matching the current level restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= din;
            r_sync2 <= r_sync1;
            r_rise  <= w_accept & r_sync2;
            if (w_accept) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else if (w_diff) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign dout = r_deb;
    assign rise = r_rise;

endmodule

// File: rtl/bikelight_multi.sv
// N_CH-channel bike light controller with phase-coherent shared blink and PWM timebases.
// Build option: define BIKELIGHT_LONGPRESS_OFF_EN to force a channel OFF after a long hold.
module bikelight_multi
    import bikelight_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned BLINK_HALF = 1024,
    parameter int unsigned PWM_BITS   = 4,
    parameter int unsigned DIM_DUTY   = 4
`ifdef BIKELIGHT_LONGPRESS_OFF_EN
    ,
    parameter int unsigned LONG_CYCLES = 4096
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        btn,
    output logic [MODE_W*N_CH-1:0] state,
    output logic [N_CH-1:0]        led
);
    localparam int unsigned      BLK_W      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam int unsigned      CMP_W      = PWM_BITS + 1;
    localparam logic [CMP_W-1:0] DUTY_CMP   = CMP_W'(DIM_DUTY);

    logic [BLK_W-1:0]    r_blink_cnt;
    logic                r_blink_phase;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_dim_on;

    // Shared timebases; entering BLINK never restarts them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_pwm_cnt     <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
        end
    end

    assign w_dim_on = ({1'b0, r_pwm_cnt} < DUTY_CMP);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic  w_dout;
        logic  w_rise;
        logic  w_adv;
        logic  w_force_off;
        mode_t r_mode;
        mode_t w_mode_nxt;
        logic  w_led_nxt;
        logic  r_led;

        bikelight_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (btn[g]),
            .dout (w_dout),
            .rise (w_rise)
        );

        assign w_adv = w_rise & w_dout;

`ifdef BIKELIGHT_LONGPRESS_OFF_EN
        localparam int unsigned       HOLD_W   = $clog2(LONG_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
        localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_CYCLES - 1);

        logic [HOLD_W-1:0] r_hold;
        logic              r_long;

        // Hold counter saturates so one long press forces OFF exactly once.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold <= '0;
                r_long <= 1'b0;
            end else if (w_dout) begin
                r_long <= (r_hold == HOLD_PRE);
                if (r_hold != HOLD_MAX) begin
                    r_hold <= r_hold + HOLD_W'(1);
                end
            end else begin
                r_hold <= '0;
                r_long <= 1'b0;
            end
        end

        assign w_force_off = r_long;
`else
        assign w_force_off = 1'b0;
`endif

        // Mode next-state and LED drive.
        always_comb begin
            w_mode_nxt = r_mode;
            w_led_nxt  = 1'b0;
            if (w_force_off) begin
                w_mode_nxt = MODE_OFF;
            end else if (w_adv) begin
                w_mode_nxt = next_mode(r_mode);
            end
            case (r_mode)
                MODE_ON:    w_led_nxt = 1'b1;
                MODE_BLINK: w_led_nxt = r_blink_phase;
                MODE_DIM:   w_led_nxt = w_dim_on;
                default:    w_led_nxt = 1'b0;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mode <= MODE_OFF;
                r_led  <= 1'b0;
            end else begin
                r_mode <= w_mode_nxt;
                r_led  <= w_led_nxt;
            end
        end

        assign state[MODE_W*g +: MODE_W] = r_mode;
        assign led[g]                    = r_led;
    end

endmodule

// File: tb/tb_bikelight_multi.sv
// Self-checking bench for bikelight_multi: directed vector table, waveform checks, random vs model.
module tb_bikelight_multi;

    localparam int unsigned NC   = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned BH   = 8;
    localparam int unsigned PB   = 3;
    localparam int unsigned DUTY = 2;
    localparam int unsigned LONG = 20;
    localparam int unsigned HL   = DEB + 2;
`ifdef BIKELIGHT_LONGPRESS_OFF_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [NC-1:0]   btn;
    logic [4*NC-1:0] state;
    logic [NC-1:0]   led;

    bikelight_multi #(
        .N_CH      (NC),
        .DEB_CYCLES(DEB),
        .BLINK_HALF(BH),
        .PWM_BITS  (PB),
`ifdef BIKELIGHT_LONGPRESS_OFF_EN
        .DIM_DUTY  (DUTY),
        .LONG_CYCLES(LONG)
`else
        .DIM_DUTY  (DUTY)
`endif
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (btn),
        .state(state),
        .led  (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] btn;
        int         ncyc;
        logic [7:0] exp_state;
    } vec_t;
    vec_t vecs[$];

    // Behavioural reference: mode index 0..3, debounce from a sample-history window.
    bit      m_hist [NC][HL];
    int      m_mode [NC];
    bit      m_deb  [NC];
    bit      m_padv [NC];
    bit      m_poff [NC];
    int      m_run  [NC];
    logic [NC-1:0] m_led;
    int      m_n;

    logic samp [32];
    int   hi_cnt;
    bit   ok;
    int   t_a, t_b, t_c;
    logic [1:0] rb;
    int   rlen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [1:0] b, input int n, input logic [7:0] s);
        vec_t v;
        v.btn = b;
        v.ncyc = n;
        v.exp_state = s;
        vecs.push_back(v);
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            btn = vecs[i].btn;
            repeat (vecs[i].ncyc) @(negedge clk);
            check($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].exp_state));
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < HL; j++) m_hist[c][j] = 1'b0;
            m_mode[c] = 0;
            m_deb[c]  = 1'b0;
            m_padv[c] = 1'b0;
            m_poff[c] = 1'b0;
            m_run[c]  = 0;
        end
        m_led = '0;
        m_n   = 0;
    endtask

    // One clock edge of the reference, using the btn value the DUT sampled on that edge.
    task automatic model_step();
        for (int c = 0; c < NC; c++) begin
            bit deb_before;
            bit same;
            bit deb_new;
            case (m_mode[c])
                1:       m_led[c] = 1'b1;
                2:       m_led[c] = ((m_n / BH) % 2) == 1;
                3:       m_led[c] = (m_n % (1 << PB)) < DUTY;
                default: m_led[c] = 1'b0;
            endcase
            if (m_poff[c]) m_mode[c] = 0;
            else if (m_padv[c]) m_mode[c] = (m_mode[c] + 1) % 4;
            deb_before = m_deb[c];
            for (int j = HL - 1; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
            m_hist[c][0] = btn[c];
            same = 1'b1;
            for (int j = 3; j < HL; j++) if (m_hist[c][j] != m_hist[c][2]) same = 1'b0;
            deb_new = (same && (m_hist[c][2] != deb_before)) ? m_hist[c][2] : deb_before;
            m_padv[c] = deb_new && !deb_before;
            if (deb_before) m_run[c] = (m_run[c] > int'(LONG)) ? m_run[c] : m_run[c] + 1;
            else m_run[c] = 0;
            m_poff[c] = LONG_EN && (m_run[c] == int'(LONG));
            m_deb[c] = deb_new;
        end
        m_n++;
    endtask

    function automatic logic [7:0] model_state();
        logic [7:0] s;
        s = '0;
        for (int c = 0; c < NC; c++) s[4*c +: 4] = 4'(1 << m_mode[c]);
        return s;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed vector table (ch0 at ON, ch1 at OFF when it starts).
        for (int k = 0; k < 5; k++) begin
            add(2'b10, 3, 8'h12);
            add(2'b00, 1, 8'h12);
        end
        add(2'b10, 6, 8'h12); add(2'b00, 1, 8'h22); add(2'b00, 8, 8'h22);
        add(2'b01, 6, 8'h22); add(2'b01, 1, 8'h24); add(2'b00, 8, 8'h24);
        t_a = vecs.size();
        add(2'b01, 6, 8'h24); add(2'b01, 1, 8'h28); add(2'b00, 8, 8'h28);
        t_b = vecs.size();
        add(2'b01, 6, 8'h28); add(2'b01, 1, 8'h21); add(2'b00, 8, 8'h21);
        add(2'b01, 7, 8'h22); add(2'b00, 8, 8'h22);
        add(2'b11, 6, 8'h22); add(2'b11, 1, 8'h44); add(2'b00, 8, 8'h44);
        add(2'b01, 7, 8'h48); add(2'b00, 8, 8'h48);
        add(2'b01, 7, 8'h41); add(2'b00, 8, 8'h41);
        add(2'b01, 6, 8'h41); add(2'b01, 1, 8'h42);
`ifdef BIKELIGHT_LONGPRESS_OFF_EN
        add(2'b01, 19, 8'h42); add(2'b01, 1, 8'h41); add(2'b01, 13, 8'h41); add(2'b00, 8, 8'h41);
`else
        add(2'b01, 19, 8'h42); add(2'b01, 1, 8'h42); add(2'b01, 13, 8'h42); add(2'b00, 8, 8'h42);
`endif
        t_c = vecs.size();

        btn   = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset state", 32'(state), 32'h11);
        check("reset led", 32'(led), 32'h0);
        rst_n = 1'b1;

        // Clean press on ch0: advance exactly on the 7th sampling edge, LED one clock later.
        btn = 2'b01;
        repeat (6) @(negedge clk);
        check("press edge6 state", 32'(state), 32'h11);
        @(negedge clk);
        check("press edge7 state", 32'(state), 32'h12);
        check("press edge7 led", 32'(led), 32'h0);
        @(negedge clk);
        check("press edge8 led", 32'(led), 32'h1);
        repeat (2) @(negedge clk);
        btn = 2'b00;
        repeat (8) @(negedge clk);
        check("release state", 32'(state), 32'h12);
        check("release led", 32'(led), 32'h1);

        apply_vecs(0, t_a);

        // ch0 in BLINK: period 16, 8 high.
        for (int t = 0; t < 32; t++) begin
            @(negedge clk);
            samp[t] = led[0];
        end
        hi_cnt = 0;
        for (int t = 0; t < 16; t++) hi_cnt += int'(samp[t]);
        check("blink duty", 32'(hi_cnt), 32'd8);
        ok = 1'b1;
        for (int t = 0; t < 16; t++) if (samp[t] != samp[t+16]) ok = 1'b0;
        check("blink period", 32'(ok), 32'd1);
        ok = 1'b1;
        for (int t = 0; t < 8; t++) if (samp[t] == samp[t+8]) ok = 1'b0;
        check("blink half", 32'(ok), 32'd1);

        apply_vecs(t_a, t_b);

        // ch0 in DIM: 2 high of every 8.
        for (int t = 0; t < 16; t++) begin
            @(negedge clk);
            samp[t] = led[0];
        end
        hi_cnt = 0;
        for (int t = 0; t < 8; t++) hi_cnt += int'(samp[t]);
        check("dim duty", 32'(hi_cnt), 32'd2);
        ok = 1'b1;
        for (int t = 0; t < 8; t++) if (samp[t] != samp[t+8]) ok = 1'b0;
        check("dim period", 32'(ok), 32'd1);

        apply_vecs(t_b, t_c);

        // Reset mid-debounce: takes effect before any clock edge and discards progress.
        btn = 2'b01;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset state", 32'(state), 32'h11);
        check("async reset led", 32'(led), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post-reset edge6 state", 32'(state), 32'h11);
        @(negedge clk);
        check("post-reset edge7 state", 32'(state), 32'h12);
        btn = 2'b00;
        repeat (8) @(negedge clk);

        // Random segments against the reference model.
        #2 rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 160; s++) begin
            rb   = 2'($urandom_range(0, 3));
            rlen = int'($urandom_range(1, 30));
            if (s == 80) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                check("rnd reset state", 32'(state), 32'(model_state()));
                @(negedge clk);
                rst_n = 1'b1;
            end
            for (int k = 0; k < rlen; k++) begin
                btn = rb;
                @(posedge clk);
                model_step();
                @(negedge clk);
                check($sformatf("rnd%0d state", s), 32'(state), 32'(model_state()));
                check($sformatf("rnd%0d led", s), 32'(led), 32'(m_led));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
